weight_accumulator19: RTL and testbench

Upstream input stage for neuron 19's potential adder. Accepts incoming synaptic weight events (FP32) over one timestep through a valid/ready handshake and sums them into a running accumulator. At timestep end it publishes the total as input_weight19, pulses weight_valid so the downstream adder can consume it, then clears for the next timestep. FP32 sums use the shared Addition_Subtraction unit, which is combinational.

---
 rtl/weight_accumulator19_pkg.sv | 12 +
 rtl/Addition_Subtraction.sv | 63 ++++++
 rtl/weight_accumulator19.sv | 108 ++++++++++
 tb/tb_weight_accumulator19.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/weight_accumulator19_pkg.sv
// Shared constants and state encoding for the neuron-19 weight accumulator.
package weight_accumulator19_pkg;

  localparam logic [31:0] FP_ZERO = 32'h00000000;
  localparam logic [31:0] FP_ONE  = 32'h3F800000;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/Addition_Subtraction.sv
// Combinational FP32 add/subtract (AddBar_Sub=1 subtracts). Denormals flush to
// zero and the result is truncated. Exception flags Inf/NaN operands or overflow.
module Addition_Subtraction (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic        Exception,
  output logic [31:0] result
);

  logic        sa, sb, s_big, s_small;
  logic [7:0]  ea, eb, e_big, e_small, diff;
  logic [23:0] ma, mb, m_big, m_small, m_shift, m_norm;
  logic [24:0] m_sum;
  logic [4:0]  pos, sh;
  logic [8:0]  e_res;

  always_comb begin
    sa = a_operand[31];
    sb = b_operand[31] ^ AddBar_Sub;
    ea = a_operand[30:23];
    eb = b_operand[30:23];
    ma = (ea == 8'd0) ? '0 : {1'b1, a_operand[22:0]};
    mb = (eb == 8'd0) ? '0 : {1'b1, b_operand[22:0]};

    if ({ea, ma} >= {eb, mb}) begin
      s_big = sa; e_big = ea; m_big = ma;
      s_small = sb; e_small = eb; m_small = mb;
    end else begin
      s_big = sb; e_big = eb; m_big = mb;
      s_small = sa; e_small = ea; m_small = ma;
    end

    diff    = e_big - e_small;
    m_shift = (diff > 8'd23) ? '0 : (m_small >> diff);

    if (s_big == s_small) m_sum = {1'b0, m_big} + {1'b0, m_shift};
    else                  m_sum = {1'b0, m_big} - {1'b0, m_shift};

    pos = '0;
    for (int unsigned i = 0; i < 24; i++) begin
      if (m_sum[i]) pos = 5'(i);
    end
    sh = 5'd23 - pos;

    m_norm = '0;
    e_res  = '0;
    result = '0;
    if (m_sum[24]) begin
      m_norm = m_sum[24:1];
      e_res  = {1'b0, e_big} + 9'd1;
      result = {s_big, e_res[7:0], m_norm[22:0]};
    end else if (m_sum[23:0] != 24'd0 && {1'b0, e_big} > {4'd0, sh}) begin
      m_norm = m_sum[23:0] << sh;
      e_res  = {1'b0, e_big} - {4'd0, sh};
      result = {s_big, e_res[7:0], m_norm[22:0]};
    end

    Exception = (ea == 8'hFF) || (eb == 8'hFF) || (e_res >= 9'd255);
    if (Exception) result = {s_big, 8'hFF, 23'd0};
  end

endmodule

// File: rtl/weight_accumulator19.sv
// Sums FP32 synaptic weight events over a timestep and publishes the total to
// neuron 19's potential adder, then holds the output stable for HOLD_CYCLES.
module weight_accumulator19
  import weight_accumulator19_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic                   ev_valid,
  input  logic [DATA_WIDTH-1:0]  ev_weight,
  output logic                   ev_ready,
  input  logic                   timestep_end,
  output logic [DATA_WIDTH-1:0]  input_weight19,
  output logic                   weight_valid,
  output logic [COUNT_WIDTH-1:0] event_count,
  output logic                   exc_flag,
  output logic                   overrun
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t                 state, state_next;
  logic [3:0]             hold_cnt, hold_next;
  logic [DATA_WIDTH-1:0]  acc, acc_next, sum;
  logic [COUNT_WIDTH-1:0] cnt, cnt_next;
  logic                   exc_acc, exc_next, add_exc;
  logic                   accept, publish;

  Addition_Subtraction u_add (
    .a_operand  (acc),
    .b_operand  (ev_weight),
    .AddBar_Sub (1'b0),
    .Exception  (add_exc),
    .result     (sum)
  );

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    publish    = 1'b0;
    case (state)
      ACCUM: begin
        if (timestep_end) begin
          publish    = 1'b1;
          state_next = HOLD;
          hold_next  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (hold_cnt == 4'd0) state_next = ACCUM;
        else                  hold_next  = hold_cnt - 4'd1;
      end
      default: state_next = ACCUM;
    endcase
  end

  assign ev_ready = (state == ACCUM);
  assign accept   = ev_valid && ev_ready;

  // Same-cycle event is folded in before the publish latch.
  always_comb begin
    acc_next = accept ? sum : acc;
    cnt_next = (accept && !(&cnt)) ? cnt + COUNT_WIDTH'(1) : cnt;
    exc_next = exc_acc | (accept & add_exc);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      acc            <= FP_ZERO;
      cnt            <= '0;
      exc_acc        <= 1'b0;
      input_weight19 <= FP_ZERO;
      event_count    <= '0;
      exc_flag       <= 1'b0;
      weight_valid   <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      weight_valid <= publish;
      if (state == HOLD && timestep_end) overrun <= 1'b1;
      if (publish) begin
        input_weight19 <= acc_next;
        event_count    <= cnt_next;
        exc_flag       <= exc_next;
        acc            <= FP_ZERO;
        cnt            <= '0;
        exc_acc        <= 1'b0;
      end else begin
        acc     <= acc_next;
        cnt     <= cnt_next;
        exc_acc <= exc_next;
      end
    end
  end

endmodule

// File: tb/tb_weight_accumulator19.sv
// Directed checks for weight_accumulator19: publish, hold, overrun, async reset,
// counter saturation and exception propagation.
module tb_weight_accumulator19;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        ev_valid, timestep_end;
  logic [31:0] ev_weight;
  logic        ev_ready, weight_valid, exc_flag, overrun;
  logic [31:0] input_weight19;
  logic [15:0] event_count;

  logic        s_ev_valid, s_timestep_end;
  logic [31:0] s_ev_weight;
  logic        s_ev_ready, s_weight_valid, s_exc_flag, s_overrun;
  logic [31:0] s_input_weight19;
  logic [1:0]  s_event_count;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  weight_accumulator19 #(.DATA_WIDTH(32), .COUNT_WIDTH(16), .HOLD_CYCLES(2)) dut (
    .CLK(CLK), .rst_n(rst_n), .ev_valid(ev_valid), .ev_weight(ev_weight),
    .ev_ready(ev_ready), .timestep_end(timestep_end), .input_weight19(input_weight19),
    .weight_valid(weight_valid), .event_count(event_count), .exc_flag(exc_flag),
    .overrun(overrun)
  );

  weight_accumulator19 #(.DATA_WIDTH(32), .COUNT_WIDTH(2), .HOLD_CYCLES(2)) dut_small (
    .CLK(CLK), .rst_n(rst_n), .ev_valid(s_ev_valid), .ev_weight(s_ev_weight),
    .ev_ready(s_ev_ready), .timestep_end(s_timestep_end), .input_weight19(s_input_weight19),
    .weight_valid(s_weight_valid), .event_count(s_event_count), .exc_flag(s_exc_flag),
    .overrun(s_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ev_valid = 1'b0; ev_weight = '0; timestep_end = 1'b0;
    s_ev_valid = 1'b0; s_ev_weight = '0; s_timestep_end = 1'b0;
    #12;
    check("rst_iw", input_weight19, 32'h0);
    check("rst_wv", {31'd0, weight_valid}, 32'd0);
    check("rst_cnt", {16'd0, event_count}, 32'd0);
    check("rst_exc", {31'd0, exc_flag}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_rdy", {31'd0, ev_ready}, 32'd1);
    @(negedge CLK); rst_n = 1'b1;
    tick();

    // empty timestep
    timestep_end = 1'b1; tick(); timestep_end = 1'b0;
    check("t1_iw", input_weight19, 32'h00000000);
    check("t1_cnt", {16'd0, event_count}, 32'd0);
    check("t1_wv", {31'd0, weight_valid}, 32'd1);
    check("t1_exc", {31'd0, exc_flag}, 32'd0);
    tick();
    check("t1_wv_pulse", {31'd0, weight_valid}, 32'd0);
    tick();

    // 1.0 + 2.0 + 0.5 = 3.5
    ev_valid = 1'b1; ev_weight = 32'h3F800000; tick();
    ev_weight = 32'h40000000; tick();
    ev_weight = 32'h3F000000; tick();
    ev_valid = 1'b0; timestep_end = 1'b1; tick(); timestep_end = 1'b0;
    check("t2_iw", input_weight19, 32'h40600000);
    check("t2_cnt", {16'd0, event_count}, 32'd3);
    check("t2_wv", {31'd0, weight_valid}, 32'd1);
    check("t2_rdy0", {31'd0, ev_ready}, 32'd0);
    tick();
    check("t2_rdy1", {31'd0, ev_ready}, 32'd0);
    tick();
    check("t2_rdy2", {31'd0, ev_ready}, 32'd1);

    // event coincident with timestep_end is included
    ev_valid = 1'b1; ev_weight = 32'h3F800000; tick();
    timestep_end = 1'b1; tick();
    ev_valid = 1'b0; timestep_end = 1'b0;
    check("t3_iw", input_weight19, 32'h40000000);
    check("t3_cnt", {16'd0, event_count}, 32'd2);
    tick(); tick();
    check("t3_rdy", {31'd0, ev_ready}, 32'd1);
    ev_valid = 1'b1; ev_weight = 32'h3F800000; tick();
    ev_valid = 1'b0; timestep_end = 1'b1; tick(); timestep_end = 1'b0;
    check("t3_fresh_iw", input_weight19, 32'h3F800000);
    check("t3_fresh_cnt", {16'd0, event_count}, 32'd1);

    // timestep_end during HOLD
    timestep_end = 1'b1; tick(); timestep_end = 1'b0;
    check("t4_ovr", {31'd0, overrun}, 32'd1);
    check("t4_wv", {31'd0, weight_valid}, 32'd0);
    check("t4_iw", input_weight19, 32'h3F800000);
    tick();
    check("t4_wv2", {31'd0, weight_valid}, 32'd0);
    tick();
    check("t4_ovr_sticky", {31'd0, overrun}, 32'd1);
    check("t4_rdy", {31'd0, ev_ready}, 32'd1);

    // async reset mid-timestep
    ev_valid = 1'b1; ev_weight = 32'h3F800000; tick(); tick();
    ev_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_iw", input_weight19, 32'h0);
    check("t5_cnt", {16'd0, event_count}, 32'd0);
    check("t5_ovr", {31'd0, overrun}, 32'd0);
    check("t5_rdy", {31'd0, ev_ready}, 32'd1);
    @(negedge CLK); rst_n = 1'b1;
    tick();
    timestep_end = 1'b1; tick(); timestep_end = 1'b0;
    check("t5_pub_iw", input_weight19, 32'h00000000);
    check("t5_pub_cnt", {16'd0, event_count}, 32'd0);
    check("t5_pub_wv", {31'd0, weight_valid}, 32'd1);
    tick(); tick();

    // exception propagation, then cleared on the next timestep
    ev_valid = 1'b1; ev_weight = 32'h7F800000; tick();
    ev_valid = 1'b0; timestep_end = 1'b1; tick(); timestep_end = 1'b0;
    check("t7_exc", {31'd0, exc_flag}, 32'd1);
    tick(); tick();
    timestep_end = 1'b1; tick(); timestep_end = 1'b0;
    check("t7_exc_clr", {31'd0, exc_flag}, 32'd0);
    tick(); tick();

    // 2-bit counter saturates at 3 while the sum reaches 5.0
    s_ev_valid = 1'b1; s_ev_weight = 32'h3F800000;
    for (int i = 0; i < 5; i++) tick();
    s_ev_valid = 1'b0; s_timestep_end = 1'b1; tick(); s_timestep_end = 1'b0;
    check("t6_cnt_sat", {30'd0, s_event_count}, 32'd3);
    check("t6_iw", s_input_weight19, 32'h40A00000);
    check("t6_wv", {31'd0, s_weight_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
